// File: rtl/r30_field_sequencer_pkg.sv
// Shared Rule 30 definitions: FSM state encoding, centre-cell helper and the per-cell rule.
`default_nettype none

package r30_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int centre_idx(input int n);
    return n / 2;
  endfunction

  // left is the higher-index neighbour, right the lower-index one
  function automatic logic r30_cell(input logic left, input logic centre, input logic right);
    return left ^ (centre | right);
  endfunction

endpackage

`default_nettype wire

// File: rtl/r30_step_comb.sv
// One combinational Rule 30 generation across an N-cell field; cells beyond either edge read 0.
`default_nettype none

module r30_step_comb
  import r30_pkg::*;
#(
  parameter int N = 128
) (
  input  logic [N-1:0] state_i,
  output logic [N-1:0] state_o
);

  logic [N+1:0] w_padded;

  assign w_padded = {1'b0, state_i, 1'b0};

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign state_o[i] = r30_cell(w_padded[i+2], w_padded[i+1], w_padded[i]);
  end

endmodule

`default_nettype wire

// File: rtl/r30_field_sequencer.sv
// Iterates one Rule 30 step array STEPS times from a seed and captures a centre-column window.
// Optional abort input enabled by defining R30_SEQ_ABORT_EN.
`default_nettype none

module r30_field_sequencer
  import r30_pkg::*;
#(
  parameter int N         = 128,
  parameter int STEPS     = 256,
  parameter int COL_START = 128,
  parameter int COL_W     = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [N-1:0]     seed,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     final_state,
  output logic [COL_W-1:0] column_slice,
  output logic             busy
`ifdef R30_SEQ_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam int CNT_W  = $clog2(STEPS + 1);
  localparam int CENTRE = centre_idx(N);

  if (N < 4 || (N % 2) != 0) begin : g_bad_n
    $error("r30_field_sequencer: N must be even and >= 4");
  end
  if (STEPS < 1) begin : g_bad_steps
    $error("r30_field_sequencer: STEPS must be >= 1");
  end
  if (COL_START + COL_W > STEPS) begin : g_bad_col
    $error("r30_field_sequencer: COL_START+COL_W exceeds STEPS");
  end

  state_e             fsm_q;
  logic [N-1:0]       state_q;
  logic [N-1:0]       state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [COL_W-1:0]   column_q;
  logic [COL_W-1:0]   column_d;
  logic               seed_ready_q;
  logic               res_valid_q;
  logic               busy_q;
  logic [31:0]        cnt_ext;
  logic               last_step;
  logic               abort_req;

`ifdef R30_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  r30_step_comb #(
    .N (N)
  ) u_step (
    .state_i (state_q),
    .state_o (state_d)
  );

  assign cnt_ext   = 32'(cnt_q);
  assign last_step = (cnt_ext == 32'(STEPS - 1));

  // Only a counter value inside the capture window matches one of the slots
  always_comb begin
    column_d = column_q;
    for (int j = 0; j < COL_W; j++) begin
      if (cnt_ext == 32'(COL_START + j)) begin
        column_d[j] = state_q[CENTRE];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= ST_IDLE;
      state_q      <= '0;
      cnt_q        <= '0;
      column_q     <= '0;
      seed_ready_q <= 1'b1;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (seed_valid && seed_ready_q) begin
            fsm_q        <= ST_RUN;
            state_q      <= seed;
            cnt_q        <= '0;
            column_q     <= '0;
            seed_ready_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort_req) begin
            fsm_q        <= ST_IDLE;
            column_q     <= '0;
            seed_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            column_q <= column_d;
            state_q  <= state_d;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (last_step) begin
              fsm_q       <= ST_DONE;
              busy_q      <= 1'b0;
              res_valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // abort takes priority over a simultaneous consume
          if (abort_req) begin
            fsm_q        <= ST_IDLE;
            column_q     <= '0;
            seed_ready_q <= 1'b1;
            res_valid_q  <= 1'b0;
          end else if (res_ready) begin
            fsm_q        <= ST_IDLE;
            seed_ready_q <= 1'b1;
            res_valid_q  <= 1'b0;
          end
        end
        default: begin
          fsm_q        <= ST_IDLE;
          seed_ready_q <= 1'b1;
          res_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign seed_ready   = seed_ready_q;
  assign res_valid    = res_valid_q;
  assign busy         = busy_q;
  assign final_state  = state_q;
  assign column_slice = column_q;

endmodule

`default_nettype wire

// File: tb/tb_r30_field_sequencer.sv
// Scoreboard bench for r30_field_sequencer: default-size instance plus a small N=64/STEPS=16 one.
`default_nettype none

module tb_r30_field_sequencer;

  localparam int N      = 128;
  localparam int STEPS  = 256;
  localparam int CS     = 128;
  localparam int CW     = 128;
  localparam int SN     = 64;
  localparam int SSTEPS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           seed_valid, seed_ready, res_valid, res_ready, busy;
  logic [N-1:0]   seed, final_state;
  logic [CW-1:0]  column_slice;
  logic           s_seed_valid, s_seed_ready, s_res_valid, s_res_ready, s_busy;
  logic [SN-1:0]  s_seed, s_final;
  logic [15:0]    s_col;
`ifdef R30_SEQ_ABORT_EN
  logic           abort, s_abort;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [127:0] fs;
    logic [127:0] col;
  } exp_t;

  exp_t sb[$];

  r30_field_sequencer #(.N(N), .STEPS(STEPS), .COL_START(CS), .COL_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed_ready(seed_ready), .seed(seed),
    .res_valid(res_valid), .res_ready(res_ready), .final_state(final_state),
    .column_slice(column_slice), .busy(busy)
`ifdef R30_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  r30_field_sequencer #(.N(SN), .STEPS(SSTEPS), .COL_START(0), .COL_W(16)) u_small (
    .clk(clk), .rst_n(rst_n), .seed_valid(s_seed_valid), .seed_ready(s_seed_ready), .seed(s_seed),
    .res_valid(s_res_valid), .res_ready(s_res_ready), .final_state(s_final),
    .column_slice(s_col), .busy(s_busy)
`ifdef R30_SEQ_ABORT_EN
    , .abort(s_abort)
`endif
  );

  function automatic logic [127:0] model_step(input logic [127:0] s, input int n);
    logic [127:0] o;
    logic l, c, r;
    o = '0;
    for (int i = 0; i < n; i++) begin
      l = (i + 1 < n) ? s[i+1] : 1'b0;
      c = s[i];
      r = (i > 0) ? s[i-1] : 1'b0;
      o[i] = l ^ (c | r);
    end
    return o;
  endfunction

  function automatic exp_t model_run(input logic [127:0] sd, input int n, input int steps,
                                     input int cs, input int cw);
    exp_t e;
    logic [127:0] s;
    s = sd;
    e.col = '0;
    for (int k = 0; k < steps; k++) begin
      if (k >= cs && k < cs + cw) e.col[k-cs] = s[n/2];
      s = model_step(s, n);
    end
    e.fs = s;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_big(input logic [127:0] sd);
    seed       = sd;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    sb.push_back(model_run(sd, N, STEPS, CS, CW));
    n_cmp++;
    if (busy !== 1'b1 || seed_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL accept: busy=%b seed_ready=%b, required busy=1 seed_ready=0", busy, seed_ready);
    end
  endtask

  task automatic wait_big_result(input string nm);
    int lat;
    lat = 0;
    while (res_valid !== 1'b1 && lat < STEPS + 40) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (lat != STEPS || res_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s latency: got %0d (res_valid=%b), required %0d", nm, lat, res_valid, STEPS);
    end
  endtask

  task automatic pop_big_compare(input string nm);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s scoreboard: result seen with no expectation queued", nm);
    end else begin
      e = sb.pop_front();
      if (final_state !== e.fs) begin
        n_bad++;
        $display("FAIL %s final_state: got %h required %h", nm, final_state, e.fs);
      end
      n_cmp++;
      if (column_slice !== e.col) begin
        n_bad++;
        $display("FAIL %s column_slice: got %h required %h", nm, column_slice, e.col);
      end
    end
  endtask

  task automatic consume_big();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++;
    if (seed_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL consume: seed_ready=%b res_valid=%b, required 1/0", seed_ready, res_valid);
    end
  endtask

  task automatic run_big(input logic [127:0] sd, input string nm);
    accept_big(sd);
    wait_big_result(nm);
    pop_big_compare(nm);
    consume_big();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({seed_ready, res_valid, busy} !== 3'b100 || final_state !== '0 || column_slice !== '0) begin
      n_bad++;
      $display("FAIL reset_big: rdy/vld/busy=%b fs=%h col=%h, required 100/0/0",
               {seed_ready, res_valid, busy}, final_state, column_slice);
    end
    n_cmp++;
    if ({s_seed_ready, s_res_valid, s_busy} !== 3'b100 || s_final !== '0 || s_col !== '0) begin
      n_bad++;
      $display("FAIL reset_small: rdy/vld/busy=%b fs=%h col=%h, required 100/0/0",
               {s_seed_ready, s_res_valid, s_busy}, s_final, s_col);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_known_column();
    exp_t e;
    int lat;
    logic [15:0] golden;
    golden = 16'hA33B;
    s_seed = '0;
    s_seed[32] = 1'b1;
    e = model_run({64'h0, s_seed}, SN, SSTEPS, 0, 16);
    s_seed_valid = 1'b1;
    tick();
    s_seed_valid = 1'b0;
    lat = 0;
    while (s_res_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (lat != SSTEPS) begin
      n_bad++;
      $display("FAIL small latency: got %0d required %0d", lat, SSTEPS);
    end
    n_cmp++;
    if (s_col !== golden) begin
      n_bad++;
      $display("FAIL small column: got %h required %h", s_col, golden);
    end
    n_cmp++;
    if (s_final !== e.fs[SN-1:0]) begin
      n_bad++;
      $display("FAIL small final: got %h required %h", s_final, e.fs[SN-1:0]);
    end
    s_res_ready = 1'b1;
    tick();
    s_res_ready = 1'b0;
    n_cmp++;
    if (s_seed_ready !== 1'b1 || s_res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL small consume: rdy=%b vld=%b required 1/0", s_seed_ready, s_res_valid);
    end
  endtask

  task automatic test_random();
    logic [127:0] sd;
    for (int k = 0; k < 20; k++) begin
      sd = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_big(sd, "random");
    end
  endtask

  task automatic test_zero_seed();
    run_big('0, "zero");
  endtask

  task automatic test_back_to_back_stall();
    logic [127:0] sa, sbd, fs_hold;
    logic [127:0] col_hold;
    sa  = {$urandom(), $urandom(), $urandom(), $urandom()};
    sbd = {$urandom(), $urandom(), $urandom(), $urandom()};
    accept_big(sa);
    seed       = sbd;
    seed_valid = 1'b1;
    wait_big_result("stall_a");
    pop_big_compare("stall_a");
    fs_hold  = final_state;
    col_hold = column_slice;
    for (int k = 0; k < 50; k++) begin
      tick();
      n_cmp++;
      if ({res_valid, seed_ready, busy} !== 3'b100 || final_state !== fs_hold ||
          column_slice !== col_hold) begin
        n_bad++;
        $display("FAIL stall hold cyc %0d: vld/rdy/busy=%b fs=%h col=%h, required 100 fs=%h col=%h",
                 k, {res_valid, seed_ready, busy}, final_state, column_slice, fs_hold, col_hold);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_cmp++;
    if (seed_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall release: rdy=%b busy=%b vld=%b required 1/0/0", seed_ready, busy, res_valid);
    end
    tick();
    seed_valid = 1'b0;
    sb.push_back(model_run(sbd, N, STEPS, CS, CW));
    n_cmp++;
    if (busy !== 1'b1 || seed_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL stall second accept: busy=%b rdy=%b required 1/0", busy, seed_ready);
    end
    wait_big_result("stall_b");
    pop_big_compare("stall_b");
    consume_big();
  endtask

  task automatic test_reset_mid_run();
    exp_t dropped;
    accept_big({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (7) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({seed_ready, res_valid, busy} !== 3'b100 || final_state !== '0 || column_slice !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: rdy/vld/busy=%b fs=%h col=%h, required 100/0/0",
               {seed_ready, res_valid, busy}, final_state, column_slice);
    end
    dropped = sb.pop_back();
    tick();
    rst_n = 1'b1;
    tick();
    run_big({$urandom(), $urandom(), $urandom(), $urandom()}, "after_reset");
  endtask

`ifdef R30_SEQ_ABORT_EN
  task automatic test_abort();
    exp_t dropped;
    bit   seen;
    accept_big({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({seed_ready, res_valid, busy} !== 3'b100 || column_slice !== '0) begin
      n_bad++;
      $display("FAIL abort run: rdy/vld/busy=%b col=%h, required 100/0",
               {seed_ready, res_valid, busy}, column_slice);
    end
    dropped = sb.pop_back();
    seen = 1'b0;
    for (int k = 0; k < STEPS + 20; k++) begin
      tick();
      if (res_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL abort no_result: res_valid rose=1, required 0");
    end
    abort = 1'b1;
    accept_big({$urandom(), $urandom(), $urandom(), $urandom()});
    abort = 1'b0;
    wait_big_result("abort_idle");
    pop_big_compare("abort_idle");
    consume_big();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    seed_valid   = 1'b0;
    res_ready    = 1'b0;
    seed         = '0;
    s_seed_valid = 1'b0;
    s_res_ready  = 1'b0;
    s_seed       = '0;
`ifdef R30_SEQ_ABORT_EN
    abort        = 1'b0;
    s_abort      = 1'b0;
`endif
    test_reset();
    test_known_column();
    test_random();
    test_zero_seed();
    test_back_to_back_stall();
    test_reset_mid_run();
`ifdef R30_SEQ_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
